// File: rtl/vga_axi_mem_ctrl_if.sv
// vga_axi_mem_ctrl_if: AXI4-Lite read-channel bundle between the VGA word fetcher and memory
interface vga_axi_mem_ctrl_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_ADDR_WIDTH-1:0] m_araddr_o;
  logic [2:0] m_arprot_o;
  logic m_arvalid_o;
  logic m_arrdy_i;
  logic [AXI_DATA_WIDTH-1:0] m_rdata_i;
  logic m_rvalid_i;
  logic m_rrdy_o;
  logic [1:0] m_rresp_i;
  modport master(
    output m_araddr_o, m_arprot_o, m_arvalid_o, m_rrdy_o,
    input m_arrdy_i, m_rdata_i, m_rvalid_i, m_rresp_i
  );
  modport slave(
    input m_araddr_o, m_arprot_o, m_arvalid_o, m_rrdy_o,
    output m_arrdy_i, m_rdata_i, m_rvalid_i, m_rresp_i
  );
endinterface

// File: rtl/vga_axi_mem_ctrl.sv
// vga_axi_mem_ctrl: fetches one frame-buffer word per new pixel word over an AXI4-Lite read master
module vga_axi_mem_ctrl #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int PXL_CTR_WIDTH = 10,
  parameter int LINE_CTR_WIDTH = 10,
  parameter int H_PIXELS = 640,
  parameter int V_LINES = 480,
  parameter int PXL_WIDTH = 16,
  parameter longint unsigned BASE_ADDR = 0
) (
  input  logic m_aclk_i,
  input  logic m_arstn_i,
  input  logic [PXL_CTR_WIDTH-1:0] pxl_ctr_i,
  input  logic [LINE_CTR_WIDTH-1:0] line_ctr_i,
  vga_axi_mem_ctrl_if.master m,
  output logic [AXI_DATA_WIDTH-1:0] pxl_data_o,
  output logic pxl_data_vld_o,
  output logic rresp_err_o
);
  localparam int SHIFT = $clog2(AXI_DATA_WIDTH / PXL_WIDTH);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic [63:0] pos, full;
  logic [AXI_ADDR_WIDTH-1:0] addr, last_addr;
  logic last_vld, in_range;
  always_comb begin
    pos = 64'(line_ctr_i) * 64'(H_PIXELS) + 64'(pxl_ctr_i);
    full = 64'(BASE_ADDR) + (pos >> SHIFT) * 64'(BYTES);
    addr = full[AXI_ADDR_WIDTH-1:0];
    in_range = (32'(pxl_ctr_i) < H_PIXELS) && (32'(line_ctr_i) < V_LINES);
  end
  assign m.m_arprot_o = 3'b000;
  always_ff @(posedge m_aclk_i or posedge m_arstn_i)
    if (m_arstn_i) begin
      state <= IDLE;
      m.m_araddr_o <= '0;
      m.m_arvalid_o <= 1'b0;
      m.m_rrdy_o <= 1'b0;
      pxl_data_o <= '0;
      pxl_data_vld_o <= 1'b0;
      rresp_err_o <= 1'b0;
      last_addr <= '0;
      last_vld <= 1'b0;
    end else begin
      pxl_data_vld_o <= 1'b0;
      rresp_err_o <= 1'b0;
      case (state)
        IDLE: if (in_range && (!last_vld || addr != last_addr)) begin
          m.m_araddr_o <= addr;
          last_addr <= addr;
          last_vld <= 1'b1;
          m.m_arvalid_o <= 1'b1;
          state <= ADDR;
        end
        ADDR: if (m.m_arrdy_i) begin
          m.m_arvalid_o <= 1'b0;
          m.m_rrdy_o <= 1'b1;
          state <= DATA;
        end
        DATA: if (m.m_rvalid_i) begin
          m.m_rrdy_o <= 1'b0;
          state <= IDLE;
          if (m.m_rresp_i == 2'b00) begin
            pxl_data_o <= m.m_rdata_i;
            pxl_data_vld_o <= 1'b1;
          end else begin
            // error response: forget the word so the same address is fetched again
            rresp_err_o <= 1'b1;
            last_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vga_axi_mem_ctrl.sv
// tb_vga_axi_mem_ctrl: table-driven bench for the VGA frame-buffer AXI read fetcher
module tb_vga_axi_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] pxl = '0;
  logic [9:0] line = '0;
  logic [63:0] pxl_data;
  logic pxl_vld, err;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int pxl;
    int line;
    bit req;
    logic [31:0] addr;
    int ard;
    int rd;
    logic [63:0] data;
    logic [1:0] resp;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [12];

  vga_axi_mem_ctrl_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) bus ();

  vga_axi_mem_ctrl dut (
    .m_aclk_i(clk),
    .m_arstn_i(rst),
    .pxl_ctr_i(pxl),
    .line_ctr_i(line),
    .m(bus.master),
    .pxl_data_o(pxl_data),
    .pxl_data_vld_o(pxl_vld),
    .rresp_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = bus.m_arvalid_o;
    end
  endtask

  task automatic no_req(input string name);
    bit any;
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any |= bus.m_arvalid_o;
    end
    check(name, 64'(any), 64'(0));
  endtask

  task automatic serve(input logic [31:0] addr, input int ard, input int rd,
                       input logic [63:0] data, input logic [1:0] resp, input logic [63:0] exp);
    check("araddr", 64'(bus.m_araddr_o), 64'(addr));
    check("arprot", 64'(bus.m_arprot_o), 64'(0));
    for (int i = 0; i < ard; i++) begin
      @(negedge clk);
      check("arvalid_hold", 64'(bus.m_arvalid_o), 64'(1));
      check("araddr_hold", 64'(bus.m_araddr_o), 64'(addr));
      check("rrdy_early", 64'(bus.m_rrdy_o), 64'(0));
    end
    bus.m_arrdy_i = 1'b1;
    @(negedge clk);
    bus.m_arrdy_i = 1'b0;
    check("arvalid_drop", 64'(bus.m_arvalid_o), 64'(0));
    check("rrdy_up", 64'(bus.m_rrdy_o), 64'(1));
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      check("rrdy_hold", 64'(bus.m_rrdy_o), 64'(1));
      check("vld_early", 64'(pxl_vld), 64'(0));
    end
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i = data;
    bus.m_rresp_i = resp;
    @(negedge clk);
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i = '0;
    bus.m_rresp_i = 2'b00;
    check("rrdy_drop", 64'(bus.m_rrdy_o), 64'(0));
    check("data_vld", 64'(pxl_vld), 64'(resp == 2'b00));
    check("rresp_err", 64'(err), 64'(resp != 2'b00));
    check("pxl_data", pxl_data, exp);
    @(negedge clk);
    check("vld_pulse", 64'(pxl_vld), 64'(0));
    check("err_pulse", 64'(err), 64'(0));
    if (resp == 2'b00) check("single_xfer", 64'(bus.m_arvalid_o), 64'(0));
  endtask

  initial begin
    bit seen;
    tbl[0]  = '{0,   0,   1'b1, 32'h0,     0, 0, 64'h1,    2'b00, 64'h1};
    tbl[1]  = '{1,   0,   1'b0, 32'h0,     0, 0, 64'h0,    2'b00, 64'h1};
    tbl[2]  = '{3,   0,   1'b0, 32'h0,     0, 0, 64'h0,    2'b00, 64'h1};
    tbl[3]  = '{4,   0,   1'b1, 32'h8,     0, 0, 64'h1111, 2'b00, 64'h1111};
    tbl[4]  = '{0,   1,   1'b1, 32'h500,   0, 0, 64'h2222, 2'b00, 64'h2222};
    tbl[5]  = '{636, 479, 1'b1, 32'h95FF8, 3, 2, 64'h3333, 2'b00, 64'h3333};
    tbl[6]  = '{639, 479, 1'b0, 32'h0,     0, 0, 64'h0,    2'b00, 64'h3333};
    tbl[7]  = '{700, 0,   1'b0, 32'h0,     0, 0, 64'h0,    2'b00, 64'h3333};
    tbl[8]  = '{0,   500, 1'b0, 32'h0,     0, 0, 64'h0,    2'b00, 64'h3333};
    tbl[9]  = '{640, 10,  1'b0, 32'h0,     0, 0, 64'h0,    2'b00, 64'h3333};
    tbl[10] = '{8,   2,   1'b1, 32'hA10,   2, 1, 64'hDEAD, 2'b10, 64'h3333};
    tbl[11] = '{8,   2,   1'b1, 32'hA10,   0, 0, 64'h4444, 2'b00, 64'h4444};
    bus.m_arrdy_i = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i = '0;
    bus.m_rresp_i = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 64'(bus.m_arvalid_o), 64'(0));
    check("rst_rrdy", 64'(bus.m_rrdy_o), 64'(0));
    check("rst_araddr", 64'(bus.m_araddr_o), 64'(0));
    check("rst_pxl_data", pxl_data, 64'(0));
    check("rst_vld", 64'(pxl_vld), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pxl = 10'(tbl[i].pxl);
      line = 10'(tbl[i].line);
      if (tbl[i].req) begin
        wait_req(seen);
        check($sformatf("req_seen[%0d]", i), 64'(seen), 64'(1));
        if (seen) serve(tbl[i].addr, tbl[i].ard, tbl[i].rd, tbl[i].data, tbl[i].resp, tbl[i].exp);
      end else begin
        no_req($sformatf("no_req[%0d]", i));
        check($sformatf("data_kept[%0d]", i), pxl_data, tbl[i].exp);
      end
    end
    // reset in the middle of an address phase, between clock edges
    pxl = 10'd12;
    line = 10'd0;
    wait_req(seen);
    check("mid_req_seen", 64'(seen), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_arvalid", 64'(bus.m_arvalid_o), 64'(0));
    check("async_rrdy", 64'(bus.m_rrdy_o), 64'(0));
    check("async_araddr", 64'(bus.m_araddr_o), 64'(0));
    check("async_pxl_data", pxl_data, 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_req(seen);
    check("restart_seen", 64'(seen), 64'(1));
    if (seen) serve(32'h18, 1, 0, 64'h5555, 2'b00, 64'h5555);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
